mem_stage_lsu: RTL and testbench

Load/store unit for the MEM stage of the 5-stage RISC-V pipeline. It consumes the EX/MEM access (MemRead, MemWrite, address, store data, funct3) and runs it on a variable-latency req/ack data-memory bus, generating byte enables and load sign/zero extension. It holds the pipeline with `mem_stall` until the access completes. The result it produces feeds the MEM/WB register.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/load_extend.sv | 34 +++
 rtl/mem_stage_lsu.sv | 180 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, func3 encodings and byte-enable helper for the MEM-stage load/store unit.
package lsu_pkg;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Store byte enables from access size and byte offset within the word.
  function automatic logic [BE_W-1:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
    logic [BE_W-1:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select plus sign/zero extension of a returned read word.
module load_extend
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] bus_rdata,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        func3,
  output logic [WORD_W-1:0] ext_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword lane, then extend according to func3.
  always_comb begin
    byte_sel   = 8'h00;
    half_sel   = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ext_data_c = bus_rdata;
    case (addr_lo)
      2'b00:   byte_sel = bus_rdata[7:0];
      2'b01:   byte_sel = bus_rdata[15:8];
      2'b10:   byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    case (func3)
      F3_B:    ext_data_c = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ext_data_c = {24'h000000, byte_sel};
      F3_H:    ext_data_c = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ext_data_c = {16'h0000, half_sel};
      default: ext_data_c = bus_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs one EX/MEM access on a req/ack data bus and stalls the pipeline meanwhile.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DM_ADDRESS  = 9,
  parameter int unsigned TIMEOUT_CYC = 15
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic                  mem_stall,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  addr_err,
  output logic                  timeout_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DM_ADDRESS-3:0] bus_addr,
  output logic [BE_W-1:0]       bus_be,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_t state, state_d;

  logic [CNT_W-1:0]      cnt, cnt_d;
  logic                  access, f3_ok, align_ok, acc_ok;
  logic [DATA_W-1:0]     st_data;
  logic [WORD_W-1:0]     ext_data;

  logic                  bus_req_d, bus_we_d;
  logic [DM_ADDRESS-3:0] bus_addr_d;
  logic [BE_W-1:0]       bus_be_d;
  logic [DATA_W-1:0]     bus_wdata_d, rd_data_d;
  logic                  rd_valid_d, addr_err_d, timeout_err_d;
  logic                  is_load, is_load_d;
  logic [2:0]            ld_f3, ld_f3_d;
  logic [1:0]            ld_off, ld_off_d;

  // Decode the incoming access: legality, alignment and lane-replicated store data.
  always_comb begin
    access   = MemRead | MemWrite;
    f3_ok    = 1'b0;
    align_ok = 1'b1;
    st_data  = wr_data;
    case (func3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = ~MemWrite;
      default:          f3_ok = 1'b0;
    endcase
    case (func3[1:0])
      2'b01:   align_ok = ~addr[0];
      2'b10:   align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    case (func3[1:0])
      2'b00:   st_data = {4{wr_data[7:0]}};
      2'b01:   st_data = {2{wr_data[15:0]}};
      default: st_data = wr_data;
    endcase
    acc_ok = f3_ok & align_ok;
  end

  load_extend u_load_extend (
    .bus_rdata  (bus_rdata),
    .addr_lo    (ld_off),
    .func3      (ld_f3),
    .ext_data_c (ext_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state, next register values and the combinational stall.
  always_comb begin
    state_d       = state;
    cnt_d         = '0;
    bus_req_d     = bus_req;
    bus_we_d      = bus_we;
    bus_addr_d    = bus_addr;
    bus_be_d      = bus_be;
    bus_wdata_d   = bus_wdata;
    rd_data_d     = rd_data;
    rd_valid_d    = 1'b0;
    addr_err_d    = 1'b0;
    timeout_err_d = 1'b0;
    is_load_d     = is_load;
    ld_f3_d       = ld_f3;
    ld_off_d      = ld_off;
    mem_stall     = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          mem_stall = 1'b1;
          if (acc_ok) begin
            bus_req_d   = 1'b1;
            bus_we_d    = MemWrite;
            bus_addr_d  = addr[DM_ADDRESS-1:2];
            bus_be_d    = MemWrite ? be_gen(func3, addr[1:0]) : 4'b1111;
            bus_wdata_d = MemWrite ? st_data : '0;
            is_load_d   = ~MemWrite;
            ld_f3_d     = func3;
            ld_off_d    = addr[1:0];
            state_d     = BUSY;
          end else begin
            addr_err_d = 1'b1;
            rd_data_d  = '0;
            state_d    = DONE;
          end
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        cnt_d     = cnt + CNT_W'(1);
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (is_load) begin
            rd_data_d  = ext_data;
            rd_valid_d = 1'b1;
          end
          state_d = DONE;
        end else if (cnt == TO_LAST) begin
          bus_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          rd_data_d     = '0;
          state_d       = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset) mem_stall = 1'b0;
  end

  // Bus payload, result and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      addr_err    <= 1'b0;
      timeout_err <= 1'b0;
      is_load     <= 1'b0;
      ld_f3       <= 3'b000;
      ld_off      <= 2'b00;
    end else begin
      cnt         <= cnt_d;
      bus_req     <= bus_req_d;
      bus_we      <= bus_we_d;
      bus_addr    <= bus_addr_d;
      bus_be      <= bus_be_d;
      bus_wdata   <= bus_wdata_d;
      rd_data     <= rd_data_d;
      rd_valid    <= rd_valid_d;
      addr_err    <= addr_err_d;
      timeout_err <= timeout_err_d;
      is_load     <= is_load_d;
      ld_f3       <= ld_f3_d;
      ld_off      <= ld_off_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with hand-computed expectations.
module tb_mem_stage_lsu;

  logic        clk;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [2:0]  func3;
  logic        mem_stall;
  logic [31:0] rd_data;
  logic        rd_valid, addr_err, timeout_err;
  logic        bus_req, bus_we;
  logic [6:0]  bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  int          stall_n, req_n;
  logic [31:0] p_addr, p_be, p_we, p_wdata;

  mem_stage_lsu #(.DATA_W(32), .DM_ADDRESS(9), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wr_data(wr_data), .func3(func3), .mem_stall(mem_stall),
    .rd_data(rd_data), .rd_valid(rd_valid), .addr_err(addr_err),
    .timeout_err(timeout_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, observed running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an access in IDLE and run until the DONE cycle; ack_k < 0 means never ack.
  task automatic access(input logic rd, input logic wr, input logic [8:0] a,
                        input logic [31:0] d, input logic [2:0] f3,
                        input int ack_k, input logic [31:0] rdata);
    logic done;
    done = 1'b0; stall_n = 0; req_n = 0;
    p_addr = '0; p_be = '0; p_we = '0; p_wdata = '0;
    MemRead = rd; MemWrite = wr; addr = a; wr_data = d; func3 = f3;
    for (int c = 0; c < 40; c++) begin
      bus_ack   = (c == ack_k);
      bus_rdata = (c == ack_k) ? rdata : 32'h0;
      #1;
      if (!mem_stall) begin
        done = 1'b1;
        break;
      end
      stall_n++;
      if (bus_req) req_n++;
      if (c == 1) begin
        p_addr = 32'(bus_addr); p_be = 32'(bus_be); p_we = 32'(bus_we); p_wdata = bus_wdata;
      end
      tick();
    end
    bus_ack = 1'b0;
    chk("access_done", 32'(done), 32'd1);
  endtask

  task automatic finish_access();
    MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wr_data = '0; func3 = '0;
    tick();
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wr_data = '0;
    func3 = '0; bus_ack = 1'b0; bus_rdata = '0;
    tick(); tick();
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'h0);
    reset = 1'b0;
    tick();

    // LW 0x008, ack at T+1
    access(1'b1, 1'b0, 9'h008, 32'h0, 3'b010, 1, 32'hDEADBEEF);
    chk("lw_stall", 32'(stall_n), 32'd2);
    chk("lw_req_cycles", 32'(req_n), 32'd1);
    chk("lw_bus_addr", p_addr, 32'd2);
    chk("lw_bus_be", p_be, 32'hF);
    chk("lw_bus_we", p_we, 32'd0);
    chk("lw_rd_valid", 32'(rd_valid), 32'd1);
    chk("lw_rd_data", rd_data, 32'hDEADBEEF);
    chk("lw_addr_err", 32'(addr_err), 32'd0);
    finish_access();
    chk("lw_rd_valid_pulse", 32'(rd_valid), 32'd0);
    chk("lw_rd_data_hold", rd_data, 32'hDEADBEEF);

    // LB / LBU / LH / LHU extension
    access(1'b1, 1'b0, 9'h003, 32'h0, 3'b000, 1, 32'h80FF1234);
    chk("lb_rd_data", rd_data, 32'hFFFFFF80);
    finish_access();
    access(1'b1, 1'b0, 9'h003, 32'h0, 3'b100, 1, 32'h80FF1234);
    chk("lbu_rd_data", rd_data, 32'h00000080);
    finish_access();
    access(1'b1, 1'b0, 9'h002, 32'h0, 3'b001, 2, 32'h80FF1234);
    chk("lh_rd_data", rd_data, 32'hFFFF80FF);
    chk("lh_stall", 32'(stall_n), 32'd3);
    finish_access();
    access(1'b1, 1'b0, 9'h000, 32'h0, 3'b101, 1, 32'h80FF1234);
    chk("lhu_rd_data", rd_data, 32'h00001234);
    finish_access();

    // SH 0x006, ack at T+3
    access(1'b0, 1'b1, 9'h006, 32'h0000ABCD, 3'b001, 3, 32'h0);
    chk("sh_stall", 32'(stall_n), 32'd4);
    chk("sh_req_cycles", 32'(req_n), 32'd3);
    chk("sh_bus_we", p_we, 32'd1);
    chk("sh_bus_be", p_be, 32'hC);
    chk("sh_bus_wdata", p_wdata, 32'hABCDABCD);
    chk("sh_bus_addr", p_addr, 32'd1);
    chk("sh_rd_valid", 32'(rd_valid), 32'd0);
    chk("sh_rd_data_hold", rd_data, 32'h00001234);
    finish_access();

    // SB 0x001, ack at T+2
    access(1'b0, 1'b1, 9'h001, 32'h0000005A, 3'b000, 2, 32'h0);
    chk("sb_bus_be", p_be, 32'h2);
    chk("sb_bus_wdata", p_wdata, 32'h5A5A5A5A);
    chk("sb_stall", 32'(stall_n), 32'd3);
    finish_access();

    // Misaligned LW and illegal func3
    access(1'b1, 1'b0, 9'h005, 32'h0, 3'b010, -1, 32'h0);
    chk("mis_stall", 32'(stall_n), 32'd1);
    chk("mis_req_cycles", 32'(req_n), 32'd0);
    chk("mis_addr_err", 32'(addr_err), 32'd1);
    chk("mis_rd_data", rd_data, 32'h0);
    chk("mis_rd_valid", 32'(rd_valid), 32'd0);
    finish_access();
    chk("mis_addr_err_pulse", 32'(addr_err), 32'd0);
    access(1'b1, 1'b0, 9'h000, 32'h0, 3'b011, -1, 32'h0);
    chk("ill_stall", 32'(stall_n), 32'd1);
    chk("ill_req_cycles", 32'(req_n), 32'd0);
    chk("ill_addr_err", 32'(addr_err), 32'd1);
    finish_access();

    // MemRead and MemWrite together act as a store
    access(1'b1, 1'b1, 9'h00C, 32'h12345678, 3'b010, 1, 32'hFFFFFFFF);
    chk("both_bus_we", p_we, 32'd1);
    chk("both_bus_be", p_be, 32'hF);
    chk("both_bus_wdata", p_wdata, 32'h12345678);
    chk("both_bus_addr", p_addr, 32'd3);
    chk("both_rd_valid", 32'(rd_valid), 32'd0);
    chk("both_rd_data", rd_data, 32'h0);
    finish_access();

    // Reset while BUSY
    MemRead = 1'b1; addr = 9'h020; func3 = 3'b010;
    tick();
    chk("rstmid_req_before", 32'(bus_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmid_req_async", 32'(bus_req), 32'd0);
    chk("rstmid_rd_valid", 32'(rd_valid), 32'd0);
    MemRead = 1'b0; addr = '0; func3 = '0;
    tick();
    reset = 1'b0;
    tick();
    chk("rstmid_rd_valid_after", 32'(rd_valid), 32'd0);
    chk("rstmid_stall_after", 32'(mem_stall), 32'd0);
    access(1'b1, 1'b0, 9'h020, 32'h0, 3'b010, 1, 32'hCAFEF00D);
    chk("rstmid_next_stall", 32'(stall_n), 32'd2);
    chk("rstmid_next_rd_data", rd_data, 32'hCAFEF00D);
    chk("rstmid_next_rd_valid", 32'(rd_valid), 32'd1);
    finish_access();

    // Timeout: no ack during BUSY, stray ack in DONE and IDLE
    access(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, 16, 32'h11111111);
    chk("to_stall", 32'(stall_n), 32'd16);
    chk("to_req_cycles", 32'(req_n), 32'd15);
    chk("to_timeout_err", 32'(timeout_err), 32'd1);
    chk("to_rd_valid", 32'(rd_valid), 32'd0);
    chk("to_rd_data", rd_data, 32'h0);
    finish_access();
    chk("to_timeout_pulse", 32'(timeout_err), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h22222222;
    tick();
    bus_ack = 1'b0;
    chk("stray_bus_req", 32'(bus_req), 32'd0);
    chk("stray_rd_valid", 32'(rd_valid), 32'd0);
    chk("stray_rd_data", rd_data, 32'h0);
    chk("stray_stall", 32'(mem_stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
